// File: rtl/cell_array_ctrl.sv
// Sequenced load / clear / evaluate controller for the evolvable cell array.
// Build option CELL_ARRAY_REPLICATE_EN adds the REPEAT register (slot replication).
module cell_array_ctrl #(
  parameter int DIMX          = 64,
  parameter int DIMY          = 64,
  parameter int PORT_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        avs_address,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [PORT_WIDTH-1:0]             avs_writedata,
  output logic [PORT_WIDTH-1:0]             avs_readdata,
  output logic                              avs_waitrequest,
  output logic [PORT_WIDTH-1:0]             ram_data,
  output logic [DIMX*4/PORT_WIDTH*DIMY-1:0] write_en,
  output logic [DIMX-1:0]                   linux_in,
  input  logic [DIMX-1:0]                   linux_out
);

  localparam int SLOTS = DIMX * 4 / PORT_WIDTH;
  localparam int WORDS = SLOTS * DIMY;
  localparam int IOW   = DIMX / PORT_WIDTH;
  localparam int PW    = $clog2(WORDS);
  localparam int CW    = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, CLR_LOAD, CLR_STROBE, EVAL
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIMX-1:0]       cap_q, cap_d;
  logic [DIMX-1:0]       lin_q, lin_d;
  logic [PORT_WIDTH-1:0] ram_q, ram_d;
  logic [PORT_WIDTH-1:0] rd_q, rd_d;

  logic        wr_acc;
  logic [31:0] idx;
  logic        idx_ok;
  logic        last;

  assign wr_acc          = avs_write && (state_q == IDLE);
  assign avs_waitrequest = avs_write && (state_q != IDLE);
  assign avs_readdata    = rd_q;
  assign ram_data        = ram_q;
  assign linux_in        = lin_q;

`ifdef CELL_ARRAY_REPLICATE_EN
  logic [15:0] rep_q, rep_d;
  logic [15:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q  <= '0;
      rcnt_q <= '0;
    end else begin
      rep_q  <= rep_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign idx  = 32'(ptr_q) + 32'(rcnt_q) * 32'(SLOTS);
  assign last = (rcnt_q == rep_q);
`else
  assign idx  = 32'(ptr_q);
  assign last = 1'b1;
`endif

  assign idx_ok = idx < 32'(WORDS);

  // Enables decode straight from state so an async reset kills a live pulse.
  always_comb begin
    write_en = '0;
    if (state_q == CLR_STROBE) begin
      write_en = '1;
    end else if (state_q == STROBE && idx_ok) begin
      write_en[idx[PW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      cap_q   <= '0;
      lin_q   <= '0;
      ram_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      lin_q   <= lin_d;
      ram_q   <= ram_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    lin_d   = lin_q;
    ram_d   = ram_q;
`ifdef CELL_ARRAY_REPLICATE_EN
    rep_d   = rep_q;
    rcnt_d  = rcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (wr_acc) begin
          unique case (avs_address)
            4'd0: begin
              if (avs_writedata[2]) begin
                ptr_d = '0;
                ovf_d = 1'b0;
              end
              if (avs_writedata[0]) begin
                state_d = CLR_LOAD;
                ram_d   = '0;
                lin_d   = '0;
                ptr_d   = '0;
                ovf_d   = 1'b0;
                done_d  = 1'b0;
                cap_d   = '0;
              end else if (avs_writedata[1]) begin
                state_d = EVAL;
                done_d  = 1'b0;
                cnt_d   = '0;
              end
            end
            4'd2: begin
              state_d = LOAD;
              ram_d   = avs_writedata;
`ifdef CELL_ARRAY_REPLICATE_EN
              rcnt_d  = '0;
`endif
            end
            4'd3: begin
              ptr_d = PW'(avs_writedata % PORT_WIDTH'(WORDS));
              ovf_d = 1'b0;
            end
`ifdef CELL_ARRAY_REPLICATE_EN
            4'd15: rep_d = avs_writedata[15:0];
`endif
            default: ;
          endcase
          for (int k = 0; k < IOW; k++) begin
            if (avs_address == 4'(4 + k)) begin
              lin_d[k*PORT_WIDTH +: PORT_WIDTH] = avs_writedata;
              done_d = 1'b0;
            end
          end
        end
      end
      LOAD: state_d = STROBE;
      STROBE: begin
        if (!idx_ok) ovf_d = 1'b1;
        if (last) begin
          state_d = IDLE;
          if (ptr_q == PW'(WORDS - 1)) begin
            ptr_d = '0;
            ovf_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
`ifdef CELL_ARRAY_REPLICATE_EN
          rcnt_d = rcnt_q + 16'd1;
`endif
        end
      end
      CLR_LOAD:   state_d = CLR_STROBE;
      CLR_STROBE: state_d = IDLE;
      EVAL: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cap_d   = linux_out;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    if (avs_read) begin
      rd_d = '0;
      unique case (avs_address)
        4'd1: begin
          rd_d[0]        = (state_q != IDLE);
          rd_d[1]        = done_q;
          rd_d[2]        = ovf_q;
          rd_d[PW+15:16] = ptr_q;
        end
        4'd3: rd_d[PW-1:0] = ptr_q;
`ifdef CELL_ARRAY_REPLICATE_EN
        4'd15: rd_d[15:0] = rep_q;
`endif
        default: ;
      endcase
      for (int k = 0; k < IOW; k++) begin
        if (avs_address == 4'(4 + k)) begin
          rd_d = cap_q[k*PORT_WIDTH +: PORT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_array_ctrl.sv
// Randomized bench for cell_array_ctrl with a spec-level model and strobe monitor.
// Define CELL_ARRAY_REPLICATE_EN to also exercise the REPEAT register.
module tb_cell_array_ctrl;

  localparam int DIMX  = 64;
  localparam int DIMY  = 64;
  localparam int PWD   = 32;
  localparam int S     = 16;
  localparam int SLOTS = DIMX * 4 / PWD;
  localparam int WORDS = SLOTS * DIMY;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [PWD-1:0]   avs_writedata = '0;
  logic [PWD-1:0]   avs_readdata;
  logic             avs_waitrequest;
  logic [PWD-1:0]   ram_data;
  logic [WORDS-1:0] write_en;
  logic [DIMX-1:0]  linux_in;
  logic [DIMX-1:0]  linux_out = '0;

  cell_array_ctrl #(
    .DIMX(DIMX), .DIMY(DIMY), .PORT_WIDTH(PWD), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_data(ram_data), .write_en(write_en),
    .linux_in(linux_in), .linux_out(linux_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } stb_t;

  stb_t        sq[$];
  int          m_ptr, m_rep, m_clr_cyc;
  logic        m_ovf, m_done, m_clr_pend, m_eval_pend;
  logic [63:0] m_cap, m_lin;

  task automatic model_reset();
    m_ptr = 0; m_rep = 0; m_ovf = 0; m_done = 0;
    m_cap = '0; m_lin = '0;
    m_clr_pend = 0; m_eval_pend = 0;
    sq.delete();
  endtask

  // Every nonzero write_en cycle must be an expected strobe or clear pulse.
  always @(negedge clk) begin
    if (!rst && write_en != '0) begin
      if (&write_en) begin
        check("clr_expected", m_clr_pend, 1);
        check("clr_cycle", cyc, m_clr_cyc);
        check("clr_ram", ram_data, 0);
        check("clr_lin", linux_in, 0);
        m_clr_pend = 0;
      end else begin
        int   hit;
        stb_t e;
        hit = -1;
        check("we_onehot", $countones(write_en), 1);
        for (int i = 0; i < WORDS; i++) if (write_en[i]) hit = i;
        if (sq.size() == 0) begin
          check("we_unexpected", sq.size(), 1);
        end else begin
          e = sq.pop_front();
          check("we_idx", hit, e.idx);
          check("we_cycle", cyc, e.cyc);
          check("we_data", ram_data, e.data);
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           output int acc);
    int n;
    n = 0;
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    #1;
    while (avs_waitrequest && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("wr_accept", avs_waitrequest, 0);
    acc = cyc;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d,
                          output int rc);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    rc = cyc;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] r;
    r = '0;
    case (a)
      1: begin
        r[1] = m_done; r[2] = m_ovf;
        r[24:16] = m_ptr[8:0];
      end
      3:  r = m_ptr;
      4:  r = m_cap[31:0];
      5:  r = m_cap[63:32];
      15: r = m_rep;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int acc);
    bus_write(a, d, acc);
    case (a)
      4'd0: begin
        if (d[2]) begin m_ptr = 0; m_ovf = 0; end
        if (d[0]) begin
          m_ptr = 0; m_ovf = 0; m_done = 0; m_cap = '0; m_lin = '0;
          m_clr_pend = 1; m_clr_cyc = acc + 2;
        end else if (d[1]) begin
          m_done = 0; m_eval_pend = 1;
        end
      end
      4'd2: begin
        for (int k = 0; k <= m_rep; k++) begin
          int i;
          i = m_ptr + k * SLOTS;
          if (i < WORDS) sq.push_back('{i, d, acc + 2 + k});
          else m_ovf = 1;
        end
        if (m_ptr == WORDS - 1) begin m_ptr = 0; m_ovf = 1; end
        else m_ptr++;
      end
      4'd3: begin m_ptr = d % WORDS; m_ovf = 0; end
      4'd4: begin m_lin[31:0] = d; m_done = 0; end
      4'd5: begin m_lin[63:32] = d; m_done = 0; end
`ifdef CELL_ARRAY_REPLICATE_EN
      4'd15: m_rep = d[15:0];
`endif
      default: ;
    endcase
  endtask

  task automatic settle();
    logic [31:0] d;
    int rc;
    d = '1;
    for (int n = 0; n < 64 && d[0]; n++) bus_read(4'd1, d, rc);
    check("idle_reached", d[0], 0);
    if (m_eval_pend) begin
      m_cap = linux_out; m_done = 1; m_eval_pend = 0;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a);
    logic [31:0] d;
    int rc;
    bus_read(a, d, rc);
    check(tag, d, exp_rd(a));
  endtask

  initial begin
    logic [31:0] d;
    int acc, acc2, rc, hitc;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram", ram_data, 0);
    check("rst_we", |write_en, 0);
    check("rst_lin", linux_in, 0);
    check("rst_rd", avs_readdata, 0);
    check("rst_wait", avs_waitrequest, 0);
    @(negedge clk) rst = 1'b0;
    rd_chk("rst_status", 4'd1);

    wr(4'd2, 32'hA5A5A5A5, acc);
    check("ram_t1", ram_data, 32'hA5A5A5A5);
    wr(4'd2, 32'h0F0F0F0F, acc2);
    check("wr_gap", acc2 - acc, 3);
    settle();
    bus_read(4'd1, d, rc);
    check("ptr_two", d[24:16], 2);
    check("status_two", d, exp_rd(1));

    wr(4'd3, WORDS - 1, acc);
    wr(4'd2, 32'h1, acc);
    settle();
    bus_read(4'd1, d, rc);
    check("wrap_ptr", d[24:16], 0);
    check("wrap_ovf", d[2], 1);
    wr(4'd0, 32'h4, acc);
    bus_read(4'd1, d, rc);
    check("ptrrst_ovf", d[2], 0);

    wr(4'd4, 32'hFFFF0000, acc);
    check("io0_set", linux_in[31:0], 32'hFFFF0000);
    wr(4'd0, 32'h3, acc);
    settle();
    check("clr_lin_after", linux_in, 0);
    bus_read(4'd1, d, rc);
    check("clr_no_eval", d[1], 0);

    wr(4'd4, 32'h1234, acc);
    linux_out = 64'h0000_0000_0000_BEEF;
    wr(4'd0, 32'h2, acc);
    hitc = -1;
    for (int n = 0; n < 3 * S && hitc < 0; n++) begin
      bus_read(4'd1, d, rc);
      if (d[1]) hitc = rc;
    end
    check("eval_done_cyc", hitc, acc + S + 1);
    settle();
    rd_chk("eval_io0", 4'd4);
    linux_out = 64'h0000_DEAD_0000_CAFE;
    rd_chk("eval_hold", 4'd4);
    check("eval_hold_val", avs_readdata, 32'hBEEF);

    wr(4'd2, 32'h5A5A0001, acc);
    settle();
    wr(4'd0, 32'h2, acc);
    bus_read(4'd1, d, rc);
    check("eval_busy", d[0], 1);
    @(negedge clk);
    avs_address = 4'd7; avs_write = 1'b1;
    #1;
    check("eval_stall", avs_waitrequest, 1);
    rst = 1'b1;
    #1;
    check("arst_ram", ram_data, 0);
    check("arst_we", |write_en, 0);
    check("arst_lin", linux_in, 0);
    check("arst_rd", avs_readdata, 0);
    check("arst_wait", avs_waitrequest, 0);
    avs_write = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b0;
    rd_chk("arst_status", 4'd1);

`ifdef CELL_ARRAY_REPLICATE_EN
    wr(4'd15, 32'd3, acc);
    rd_chk("rep_rd", 4'd15);
    wr(4'd3, 32'd0, acc);
    wr(4'd2, 32'h77, acc);
    settle();
    bus_read(4'd1, d, rc);
    check("rep_ptr", d[24:16], 1);
    wr(4'd15, 32'd0, acc);
`endif

    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: begin
          wr(4'd2, $urandom, acc);
          if ($urandom_range(0, 1) == 0) settle();
        end
        4: begin
          if ($urandom_range(0, 1) == 0) wr(4'd3, $urandom, acc);
          else wr(4'd3, WORDS - 1 - $urandom_range(0, 2 * SLOTS), acc);
          settle();
        end
        5: begin
          linux_out = {$urandom, $urandom};
          wr(4'd0, $urandom_range(0, 7), acc);
          settle();
        end
        6: begin
          wr(4'(4 + $urandom_range(0, 1)), $urandom, acc);
          settle();
          check("rand_lin", linux_in, m_lin);
        end
        7: begin
          settle();
          rd_chk("rand_rd", 4'($urandom_range(0, 15)));
        end
        8: begin
          wr(4'd15, $urandom_range(0, 3), acc);
          settle();
        end
        default: begin
          settle();
          linux_out = {$urandom, $urandom};
          rd_chk("rand_status", 4'd1);
        end
      endcase
    end

    settle();
    rd_chk("end_status", 4'd1);
    rd_chk("end_io0", 4'd4);
    rd_chk("end_io1", 4'd5);
    check("end_queue", sq.size(), 0);
    check("end_clr", m_clr_pend, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
